input_debouncer: RTL

- Upstream conditioning stage for the rising-edge pulse detector. Takes a raw, asynchronous, bouncy input such as a push-button or strap.
- Synchronises the input into clk, then filters it so dout changes only after the input holds a new level for STABLE_CYCLES consecutive samples.
- dout is a clean level signal and drives the edge detector's din directly.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/input_debouncer_sync_chain.sv | 25 ++
 rtl/input_debouncer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debouncer and its users.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } deb_state_t;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Synchronous active-low reset clears every stage to 0.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the raw input through STAGES flops; stage 0 takes the raw input.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a raw asynchronous level input (button, strap).
// Synchronises din_raw, then lets dout follow only after the synchronised
// level has held a new value for STABLE_CYCLES consecutive clk edges.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds the saturating
// glitch_cnt output counting rejected candidate changes.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int unsigned GLITCH_W      = 8
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                din_raw,
    output logic                dout,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                settling
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (din_raw),
        .q      (s)
    );

    // Qualification FSM; dout/settling are registered alongside the state.
    // A returning level is tested before the qualify count, so it wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE_LO;
            cnt      <= '0;
            dout     <= 1'b0;
            settling <= 1'b0;
        end else begin
            case (state)
                IDLE_LO: begin
                    if (s) begin
                        state    <= CHK_HI;
                        cnt      <= CNT_ONE;
                        settling <= 1'b1;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state    <= IDLE_LO;
                        cnt      <= '0;
                        settling <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE_HI;
                        cnt      <= '0;
                        dout     <= 1'b1;
                        settling <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state    <= CHK_LO;
                        cnt      <= CNT_ONE;
                        settling <= 1'b1;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state    <= IDLE_HI;
                        cnt      <= '0;
                        settling <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE_LO;
                        cnt      <= '0;
                        dout     <= 1'b0;
                        settling <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= IDLE_LO;
                    cnt      <= '0;
                    dout     <= 1'b0;
                    settling <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic reject;

    // A rejection is any CHK state seeing the synchronised level fall back.
    always_comb begin
        reject = ((state == CHK_HI) && !s) || ((state == CHK_LO) && s);
    end

    // Saturating count of rejected candidates; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            glitch_cnt <= '0;
        end else if (reject && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule
